// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle sequencer driving ALU control, datapath selects and strobes.
// Build option: define ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegalInstr
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
`ifdef ILLEGAL_TRAP_EN
  localparam state_t BAD = TRAP;
`else
  localparam state_t BAD = FETCH;
`endif
  state_t state, nxt;
  logic [1:0] alu_op;
  logic [2:0] funct_ctl;
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = memReady ? DECODE : FETCH;
      DECODE:   nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_R   ? EXECUTER :
                      op == OP_I   ? EXECUTEI :
                      op == OP_BEQ ? BEQ :
                      op == OP_JAL ? JAL : BAD;
      MEMADR:   nxt = op == OP_SW ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = memReady ? MEMWB : MEMREAD;
      MEMWRITE: nxt = memReady ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: nxt = ALUWB;
      MEMWB, ALUWB, BEQ:       nxt = FETCH;
      default:  nxt = state;
    endcase
  end
  // Registered selects and strobes are decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      AdrSrc    <= 1'b0;
      MemWrite  <= 1'b0;
      RegWrite  <= 1'b0;
      ResultSrc <= 2'b10;
      ALUSrcA   <= 2'b00;
      ALUSrcB   <= 2'b10;
    end else begin
      state     <= nxt;
      AdrSrc    <= nxt inside {MEMREAD, MEMWRITE};
      MemWrite  <= nxt == MEMWRITE;
      RegWrite  <= nxt inside {MEMWB, ALUWB};
      ResultSrc <= nxt == FETCH ? 2'b10 : nxt == MEMWB ? 2'b01 : 2'b00;
      ALUSrcA   <= nxt inside {DECODE, JAL} ? 2'b01 :
                   nxt inside {MEMADR, EXECUTER, EXECUTEI, BEQ} ? 2'b10 : 2'b00;
      ALUSrcB   <= nxt inside {FETCH, JAL} ? 2'b10 :
                   nxt inside {DECODE, MEMADR, EXECUTEI} ? 2'b01 : 2'b00;
    end
  end
`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegalInstr <= 1'b0;
    else        illegalInstr <= illegalInstr | (nxt == TRAP);
  end
`else
  assign illegalInstr = 1'b0;
`endif
  always_comb begin
    PCWrite   = rst_n & ((state == FETCH & memReady) | (state == BEQ & zero) | state == JAL);
    IRWrite   = rst_n & state == FETCH & memReady;
    ImmSrc    = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    alu_op    = state == BEQ ? 2'b01 : state inside {EXECUTER, EXECUTEI} ? 2'b10 : 2'b00;
    funct_ctl = funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                funct3 == 3'b010 ? 3'b101 :
                funct3 == 3'b110 ? 3'b011 :
                funct3 == 3'b111 ? 3'b010 : 3'b000;
    ALUControl = alu_op == 2'b01 ? 3'b001 : alu_op == 2'b10 ? funct_ctl : 3'b000;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven per-cycle checks of the multicycle controller outputs.
module tb_multicycle_controller;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, memReady = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  int errors = 0, checks = 0;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011, B = 7'b1100011, J = 7'b1101111, BAD = 7'b0000000;
  // expected vector: {ill, pcw, adr, mw, irw, rw, rs[2], sa[2], sb[2], imm[2], alu[3]}
  typedef struct {
    string name;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, mr;
    logic [16:0] exp;
  } vec_t;
  vec_t v[$];
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .memReady(memReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegalInstr(illegalInstr)
  );
  always #5 clk = ~clk;
  function automatic void add(string n, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                              logic mr, logic [16:0] e);
    vec_t t;
    t.name = n; t.op = o; t.f3 = f3; t.f7 = f7; t.z = z; t.mr = mr; t.exp = e;
    v.push_back(t);
  endfunction
  task automatic chk(string n, logic [16:0] e);
    logic [16:0] got;
    got = {illegalInstr, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, e);
    end
  endtask
  initial begin
    add("r_fetch",    R, 3'b000, 1, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("r_decode",   R, 3'b000, 1, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
    add("r_exec_sub", R, 3'b000, 1, 0, 1, 17'b0_0_0_0_0_0_00_10_00_00_001);
    add("r_wb",       R, 3'b000, 1, 0, 1, 17'b0_0_0_0_0_1_00_00_00_00_000);
    add("and_fetch",  R, 3'b111, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("and_decode", R, 3'b111, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
    add("and_exec",   R, 3'b111, 0, 0, 1, 17'b0_0_0_0_0_0_00_10_00_00_010);
    add("and_wb",     R, 3'b111, 0, 0, 1, 17'b0_0_0_0_0_1_00_00_00_00_000);
    add("beq1_fetch", B, 3'b000, 0, 1, 1, 17'b0_1_0_0_1_0_10_00_10_10_000);
    add("beq1_dec",   B, 3'b000, 0, 1, 1, 17'b0_0_0_0_0_0_00_01_01_10_000);
    add("beq1_take",  B, 3'b000, 0, 1, 1, 17'b0_1_0_0_0_0_00_10_00_10_001);
    add("beq0_fetch", B, 3'b000, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_10_000);
    add("beq0_dec",   B, 3'b000, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_10_000);
    add("beq0_skip",  B, 3'b000, 0, 0, 1, 17'b0_0_0_0_0_0_00_10_00_10_001);
    add("or_fetch",   I, 3'b110, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("or_decode",  I, 3'b110, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
    add("ori_exec",   I, 3'b110, 0, 0, 1, 17'b0_0_0_0_0_0_00_10_01_00_011);
    add("ori_wb",     I, 3'b110, 0, 0, 1, 17'b0_0_0_0_0_1_00_00_00_00_000);
    add("slt_fetch",  I, 3'b010, 1, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("slt_decode", I, 3'b010, 1, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
    add("slti_exec",  I, 3'b010, 1, 0, 1, 17'b0_0_0_0_0_0_00_10_01_00_101);
    add("slti_wb",    I, 3'b010, 1, 0, 1, 17'b0_0_0_0_0_1_00_00_00_00_000);
    add("addi_fetch", I, 3'b000, 1, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("addi_dec",   I, 3'b000, 1, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
    add("addi_nosub", I, 3'b000, 1, 0, 1, 17'b0_0_0_0_0_0_00_10_01_00_000);
    add("addi_wb",    I, 3'b000, 1, 0, 1, 17'b0_0_0_0_0_1_00_00_00_00_000);
    add("sw_fetch",   SW, 3'b010, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_01_000);
    add("sw_decode",  SW, 3'b010, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_01_000);
    add("sw_memadr",  SW, 3'b010, 0, 0, 1, 17'b0_0_0_0_0_0_00_10_01_01_000);
    add("sw_wait",    SW, 3'b010, 0, 0, 0, 17'b0_0_1_1_0_0_00_00_00_01_000);
    add("sw_done",    SW, 3'b010, 0, 0, 1, 17'b0_0_1_1_0_0_00_00_00_01_000);
    add("lw_fwait",   LW, 3'b010, 0, 0, 0, 17'b0_0_0_0_0_0_10_00_10_00_000);
    add("lw_fetch",   LW, 3'b010, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("lw_decode",  LW, 3'b010, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
    add("lw_memadr",  LW, 3'b010, 0, 0, 1, 17'b0_0_0_0_0_0_00_10_01_00_000);
    add("lw_rwait1",  LW, 3'b010, 0, 0, 0, 17'b0_0_1_0_0_0_00_00_00_00_000);
    add("lw_rwait2",  LW, 3'b010, 0, 0, 0, 17'b0_0_1_0_0_0_00_00_00_00_000);
    add("lw_read",    LW, 3'b010, 0, 0, 1, 17'b0_0_1_0_0_0_00_00_00_00_000);
    add("lw_wb",      LW, 3'b010, 0, 0, 1, 17'b0_0_0_0_0_1_01_00_00_00_000);
    add("jal_fetch",  J, 3'b000, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_11_000);
    add("jal_decode", J, 3'b000, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_11_000);
    add("jal_jump",   J, 3'b000, 0, 0, 1, 17'b0_1_0_0_0_0_00_01_10_11_000);
    add("jal_wb",     J, 3'b000, 0, 0, 1, 17'b0_0_0_0_0_1_00_00_00_11_000);
    add("bad_fetch",  BAD, 3'b000, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("bad_decode", BAD, 3'b000, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
`ifdef ILLEGAL_TRAP_EN
    add("trap1",      BAD, 3'b000, 0, 1, 1, 17'b1_0_0_0_0_0_00_00_00_00_000);
    add("trap2",      R,   3'b000, 0, 1, 1, 17'b1_0_0_0_0_0_00_00_00_00_000);
    add("trap3",      R,   3'b000, 0, 1, 1, 17'b1_0_0_0_0_0_00_00_00_00_000);
`else
    add("nop_refetch", BAD, 3'b000, 0, 0, 1, 17'b0_1_0_0_1_0_10_00_10_00_000);
    add("nop_decode",  BAD, 3'b000, 0, 0, 1, 17'b0_0_0_0_0_0_00_01_01_00_000);
`endif
    @(negedge clk);
    memReady = 1'b1;
    #1 chk("reset_hold", 17'b0_0_0_0_0_0_10_00_10_00_000);
    foreach (v[k]) begin
      @(negedge clk);
      rst_n = 1'b1; op = v[k].op; funct3 = v[k].f3; funct7b5 = v[k].f7;
      zero = v[k].z; memReady = v[k].mr;
      #1 chk(v[k].name, v[k].exp);
    end
    // reset pulse clears any trap and forces strobes low
    @(negedge clk);
    rst_n = 1'b0; op = BAD; memReady = 1'b1; zero = 1'b1;
    #1 chk("rst_pulse", 17'b0_0_0_0_0_0_10_00_10_00_000);
    @(negedge clk);
    #1 chk("rst_pulse_hold", 17'b0_0_0_0_0_0_10_00_10_00_000);
    // reset during MEMWRITE drops MemWrite immediately
    @(negedge clk);
    rst_n = 1'b1; op = SW; zero = 1'b0;
    #1 chk("rsw_fetch", 17'b0_1_0_0_1_0_10_00_10_01_000);
    @(negedge clk);
    #1 chk("rsw_decode", 17'b0_0_0_0_0_0_00_01_01_01_000);
    @(negedge clk);
    #1 chk("rsw_memadr", 17'b0_0_0_0_0_0_00_10_01_01_000);
    @(negedge clk);
    memReady = 1'b0;
    #1 chk("rsw_memwrite", 17'b0_0_1_1_0_0_00_00_00_01_000);
    #2 rst_n = 1'b0;
    #1 chk("rsw_abort", 17'b0_0_0_0_0_0_10_00_10_01_000);
    @(negedge clk);
    rst_n = 1'b1; memReady = 1'b1;
    #1 chk("rsw_refetch", 17'b0_1_0_0_1_0_10_00_10_01_000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
